// File: rtl/fpu_addsub_sched_pkg.sv
// Shared FPU package: datapath sizing, operation encoding and the
// requester-tag type carried alongside the add/sub core pipeline.
package fpu_addsub_sched_pkg;

  localparam int FPU_WIDTH = 32;  // operand / result width
  localparam int FPU_LAT   = 5;   // add/sub core pipeline latency
  localparam int FPU_DEPTH = 4;   // response FIFO depth == credit limit

  // operation_select encoding shared with the add/sub core
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // requester identifiers, also the last-grant pointer values
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // One slot of the tag shift register that tracks core results
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  // Round-robin between two requesters: a lone eligible requester wins,
  // a tie goes to the requester that was not granted last.
  function automatic logic [1:0] rr_grant(input logic [1:0] elig,
                                          input logic       last);
    logic [1:0] g;
    g = elig;
    if (elig == 2'b11) begin
      g = (last == REQ1) ? 2'b01 : 2'b10;
    end
    return g;
  endfunction

endpackage

// File: rtl/fpu_addsub_sched_resp_fifo.sv
// First-word-fall-through response FIFO. The head entry is presented on
// rd_data whenever rd_valid is high and is removed by rd_en. Overflow is
// prevented upstream by the credit scheme, so no full flag is exported.
module resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // Storage array write port.
  // NOTE: the data array carries no reset; validity is tracked by count, so
  // resetting storage would only add reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; write and pop may occur together.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];

endmodule

// File: rtl/fpu_addsub_sched.sv
// Two-requester scheduler in front of a pipelined floating-point add/sub
// core. Requests are arbitrated round-robin under per-requester credits,
// issued to the core through registered operands, and the results are
// steered back to per-requester FWFT FIFOs by a tag shift register that
// runs alongside the core pipeline.
module fpu_addsub_sched
  import fpu_addsub_sched_pkg::*;
#(
  parameter int WIDTH = FPU_WIDTH,
  parameter int LAT   = FPU_LAT,
  parameter int DEPTH = FPU_DEPTH
) (
  input  logic             clk,
  input  logic             arst_n,
  // requester 0
  input  logic             rq0_valid,
  output logic             rq0_ready,
  input  logic [WIDTH-1:0] rq0_a,
  input  logic [WIDTH-1:0] rq0_b,
  input  logic             rq0_op,
  // requester 1
  input  logic             rq1_valid,
  output logic             rq1_ready,
  input  logic [WIDTH-1:0] rq1_a,
  input  logic [WIDTH-1:0] rq1_b,
  input  logic             rq1_op,
  // add/sub core
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  output logic             core_op,
  input  logic [WIDTH-1:0] core_r,
  // responses
  output logic             rs0_valid,
  input  logic             rs0_ready,
  output logic [WIDTH-1:0] rs0_data,
  output logic             rs1_valid,
  input  logic             rs1_ready,
  output logic [WIDTH-1:0] rs1_data,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]        credit0;
  logic [CW-1:0]        credit1;
  logic                 elig0;
  logic                 elig1;
  logic [1:0]           grant;
  logic                 last_grant;
  logic                 acc0;
  logic                 acc1;
  logic                 pop0;
  logic                 pop1;
  tag_t                 issue;
  tag_t [LAT-1:0]       tag_sr;
  logic                 wr0;
  logic                 wr1;

  // A requester may only be granted while it still holds a free credit,
  // which guarantees space in its FIFO when the result emerges.
  assign elig0 = rq0_valid && (credit0 < CW'(DEPTH));
  assign elig1 = rq1_valid && (credit1 < CW'(DEPTH));
  assign grant = rr_grant({elig1, elig0}, last_grant);

  // Ready is gated by reset so nothing is offered while reset is asserted.
  assign rq0_ready = grant[0] & arst_n;
  assign rq1_ready = grant[1] & arst_n;
  assign acc0      = rq0_ready;
  assign acc1      = rq1_ready;

  assign pop0 = rs0_valid & rs0_ready;
  assign pop1 = rs1_valid & rs1_ready;

  // Issue register: granted operands to the core, zero bubble otherwise.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      core_a  <= '0;
      core_b  <= '0;
      core_op <= OP_ADD;
      issue   <= '0;
    end else if (acc0) begin
      core_a  <= rq0_a;
      core_b  <= rq0_b;
      core_op <= rq0_op;
      issue   <= '{valid: 1'b1, id: REQ0};
    end else if (acc1) begin
      core_a  <= rq1_a;
      core_b  <= rq1_b;
      core_op <= rq1_op;
      issue   <= '{valid: 1'b1, id: REQ1};
    end else begin
      core_a  <= '0;
      core_b  <= '0;
      core_op <= OP_ADD;
      issue   <= '0;
    end
  end

  // Last-grant pointer; starts at requester 1 so requester 0 wins the
  // first tie, and holds its value on cycles without a grant.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      last_grant <= REQ1;
    end else if (acc0) begin
      last_grant <= REQ0;
    end else if (acc1) begin
      last_grant <= REQ1;
    end
  end

  // Tag shift register mirroring the core pipeline: its last stage lines
  // up with the core_r produced for the operands issued LAT cycles earlier.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tag_sr <= '0;
    end else begin
      tag_sr <= {tag_sr[LAT-2:0], issue};
    end
  end

  assign wr0 = tag_sr[LAT-1].valid && (tag_sr[LAT-1].id == REQ0);
  assign wr1 = tag_sr[LAT-1].valid && (tag_sr[LAT-1].id == REQ1);

  // Credits count in-flight plus buffered operations per requester.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      credit0 <= '0;
      credit1 <= '0;
    end else begin
      case ({acc0, pop0})
        2'b10:   credit0 <= credit0 + 1'b1;
        2'b01:   credit0 <= credit0 - 1'b1;
        default: credit0 <= credit0;
      endcase
      case ({acc1, pop1})
        2'b10:   credit1 <= credit1 + 1'b1;
        2'b01:   credit1 <= credit1 - 1'b1;
        default: credit1 <= credit1;
      endcase
    end
  end

  // Any outstanding credit means work is in flight or waiting to be read.
  assign busy = (credit0 != '0) || (credit1 != '0);

  resp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk      (clk),
    .arst_n   (arst_n),
    .wr_en    (wr0),
    .wr_data  (core_r),
    .rd_en    (pop0),
    .rd_valid (rs0_valid),
    .rd_data  (rs0_data)
  );

  resp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk      (clk),
    .arst_n   (arst_n),
    .wr_en    (wr1),
    .wr_data  (core_r),
    .rd_en    (pop1),
    .rd_valid (rs1_valid),
    .rd_data  (rs1_data)
  );

endmodule

// File: doc/fpu_addsub_sched.md
FPU_ADDSUB_SCHED -- requirements
Module: fpu_addsub_sched

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter LAT, default 5, cycles from the add/sub core capturing its inputs to a valid core_r.
REQ-003 Parameter DEPTH, default 4, entries in each per-requester response FIFO; this is also the per-requester credit limit.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 arst_n  in  1  asynchronous, active-low reset.
REQ-006 rq0_valid / rq1_valid  in  1  requester 0/1 has an operation pending.
REQ-007 rq0_ready / rq1_ready  out  1  requester 0/1 operation accepted this cycle.
REQ-008 rq0_a, rq0_b / rq1_a, rq1_b  in  WIDTH  operands.
REQ-009 rq0_op / rq1_op  in  1  0 = add, 1 = subtract; same encoding as the core's operation_select.
REQ-010 core_a, core_b  out  WIDTH  registered operands driven to the pipelined add/sub core.
REQ-011 core_op  out  1  registered operation select driven to the core.
REQ-012 core_r  in  WIDTH  core result.
REQ-013 rs0_valid / rs1_valid  out  1  response available for requester 0/1.
REQ-014 rs0_ready / rs1_ready  in  1  requester 0/1 consumes its response.
REQ-015 rs0_data / rs1_data  out  WIDTH  response value.
REQ-016 busy  out  1  high when any operation is in flight or any response FIFO is non-empty.

Function
REQ-017 Requester i is eligible when rqi_valid=1 and credit_i < DEPTH; credit_i counts in-flight plus buffered operations for i (range 0..DEPTH).
REQ-018 Arbitration is round-robin: if exactly one requester is eligible, it is granted; if both are, grant the one not granted last; with no grant, the last-grant pointer is unchanged.
REQ-019 rqi_ready is combinational and equals (eligible_i AND granted_i); at most one ready is high per cycle.
REQ-020 Accept (valid AND ready) loads core_a/core_b/core_op with the granted operands, sets issue_valid, and records the requester id as the tag.
REQ-021 When no request is accepted, core_a=0, core_b=0, core_op=0 and issue_valid=0 (bubble).
REQ-022 A LAT-deep shift register carries {issue_valid, tag} alongside the core pipeline; at its output, core_r is written into FIFO[tag] in the same cycle.
REQ-023 Latency: with an empty FIFO, an accept at edge k gives rsp valid after edge k+LAT+1 (edge 6 for LAT=5); throughput is one accept per cycle.
REQ-024 Each FIFO is first-word-fall-through: rsi_valid = non-empty; rsi_data = head; pop on rsi_valid AND rsi_ready.
REQ-025 credit_i increments on accept and decrements on pop; simultaneous accept and pop for the same requester leave it unchanged.
REQ-026 Credits guarantee a FIFO write never targets a full FIFO; a write and a pop in the same cycle are both performed.
REQ-027 Responses to each requester are returned in that requester's issue order.
REQ-028 rsi_valid, once high, stays high with rsi_data stable until popped.

Reset
REQ-029 While arst_n=0, asynchronously:
- all ready/valid outputs = 0
- core_a/core_b/core_op = 0; busy = 0
- credits = 0; FIFOs empty
- tag shift register invalid
- last-grant pointer = requester 1, so requester 0 wins the first tie.
REQ-030 Reset mid-operation discards in-flight and buffered results; core_r values emerging after reset release are ignored, because the shift register is invalid.

Structure
REQ-031 WIDTH, LAT and the op encoding constants (OP_ADD=0, OP_SUB=1) live in the shared FPU package.
REQ-032 The response FIFO is one sub-module, resp_fifo (params WIDTH, DEPTH), instantiated twice.
REQ-033 The core is not instantiated inside this block; the top level connects core_* to the add/sub core.

Verification
REQ-034 Single op: rq0 add 0x3F800000 + 0x40000000 accepted at edge 0 -> rs0_valid after edge 6 with rs0_data = 0x40400000.
REQ-035 Both valid every cycle for 8 cycles -> grants alternate 0,1,0,1,...; each rsi receives its 4 results in order, tagged correctly.
REQ-036 rs0_ready held 0 with rq0_valid held 1 -> exactly 4 accepts for rq0, then rq0_ready=0; one pop -> exactly one further accept.
REQ-037 Same-cycle accept and pop on requester 1 at credit=DEPTH-1 -> credit stays DEPTH-1 and no FIFO overflow.
REQ-038 arst_n pulsed low with 3 ops in flight -> all outputs 0 immediately; no rsi_valid in the 10 cycles after release without new requests.
REQ-039 Subtract op: rq1 0x40400000 - 0x3F800000 -> rs1_data = 0x40000000 after LAT+1 cycles.
